// File: rtl/snake_board_raster.sv
`default_nettype none
// ============================================================================
// Module      : snake_board_raster
// Description : Snapshots the snake core state on each frame Start, rasterizes
//               it one segment per clock into a double-buffered 16x16 bitmap
//               and answers registered per-cell body/head/food queries.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_board_raster #(
    parameter int MAX_SEG = 16,
    parameter int LOC_W   = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [3:0]               Length,
    input  logic [7:0]               Food,
    input  logic [MAX_SEG*LOC_W-1:0] Locations_Flat,
    input  logic [3:0]               Rd_X,
    input  logic [3:0]               Rd_Y,
    output logic                     Cell_Body,
    output logic                     Cell_Head,
    output logic                     Cell_Food,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Collide,
    output logic                     Start_Miss
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SCAN  = 2'd2,
        S_SWAP  = 2'd3
    } state_t;

    state_t                     r_state;
    logic [3:0]                 r_len;
    logic [7:0]                 r_food;
    logic [MAX_SEG*LOC_W-1:0]   r_locs;
    logic [3:0]                 r_idx;
    logic [255:0]               r_bmp0;
    logic [255:0]               r_bmp1;
    logic                       r_front_sel;
    logic [7:0]                 r_back_head;
    logic                       r_back_collide;
    logic [7:0]                 r_front_head;
    logic [7:0]                 r_front_food;
    logic                       r_front_collide;
    logic                       r_front_valid;
    logic                       r_cell_body;
    logic                       r_cell_head;
    logic                       r_cell_food;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_start_miss;

    logic [MAX_SEG*LOC_W-1:0]   w_shifted;
    logic [7:0]                 w_slot;
    logic [7:0]                 w_slot0;
    logic [7:0]                 w_addr;
    logic                       w_back_bit;
    logic                       w_front_bit;

    // The current slot is brought to the top byte so the index never needs
    // arithmetic on the part-select base.
    always_comb begin
        w_shifted   = r_locs << {r_idx, 3'b000};
        w_slot      = w_shifted[MAX_SEG*LOC_W-1 -: LOC_W];
        w_slot0     = r_locs[MAX_SEG*LOC_W-1 -: LOC_W];
        w_addr      = {Rd_Y, Rd_X};
        w_back_bit  = r_front_sel ? r_bmp0[w_slot] : r_bmp1[w_slot];
        w_front_bit = r_front_sel ? r_bmp1[w_addr] : r_bmp0[w_addr];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state         <= S_IDLE;
            r_len           <= 4'd0;
            r_food          <= 8'd0;
            r_locs          <= '0;
            r_idx           <= 4'd0;
            r_bmp0          <= '0;
            r_bmp1          <= '0;
            r_front_sel     <= 1'b0;
            r_back_head     <= 8'd0;
            r_back_collide  <= 1'b0;
            r_front_head    <= 8'd0;
            r_front_food    <= 8'd0;
            r_front_collide <= 1'b0;
            r_front_valid   <= 1'b0;
            r_cell_body     <= 1'b0;
            r_cell_head     <= 1'b0;
            r_cell_food     <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_start_miss    <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_cell_body <= r_front_valid & w_front_bit;
            r_cell_head <= r_front_valid & (w_addr == r_front_head);
            r_cell_food <= r_front_valid & (w_addr == r_front_food);

            if (Start && (r_state != S_IDLE)) begin
                r_start_miss <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_len   <= Length;
                        r_food  <= Food;
                        r_locs  <= Locations_Flat;
                        r_busy  <= 1'b1;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_front_sel) begin
                        r_bmp0 <= '0;
                    end else begin
                        r_bmp1 <= '0;
                    end
                    r_idx          <= 4'd0;
                    r_back_collide <= 1'b0;
                    r_state        <= S_SCAN;
                end
                S_SCAN: begin
                    if (r_idx == 4'd0) begin
                        r_back_head <= w_slot;
                    end else begin
                        if (r_front_sel) begin
                            r_bmp0[w_slot] <= 1'b1;
                        end else begin
                            r_bmp1[w_slot] <= 1'b1;
                        end
                        // A repeated body cell or a body cell on the head is a self-hit.
                        if (w_back_bit || (w_slot == w_slot0)) begin
                            r_back_collide <= 1'b1;
                        end
                    end
                    if (r_idx == r_len) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_SWAP;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_SWAP: begin
                    r_front_sel     <= ~r_front_sel;
                    r_front_head    <= r_back_head;
                    r_front_food    <= r_food;
                    r_front_collide <= r_back_collide;
                    r_front_valid   <= 1'b1;
                    r_state         <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Cell_Body  = r_cell_body;
    assign Cell_Head  = r_cell_head;
    assign Cell_Food  = r_cell_food;
    assign Busy       = r_busy;
    assign Done       = r_done;
    assign Collide    = r_front_collide;
    assign Start_Miss = r_start_miss;

endmodule
`default_nettype wire
